candy_alu_arbiter: RTL
======================

Name: candy_alu_arbiter

Overview:
- Shares the single candy_alu between two requesters (port 0: issue slot A, port 1: issue slot B).
- Each port has a valid/ready request handshake and a valid/ready response handshake.
- Arbitration is round-robin between the two ports; only one operation is in flight at a time.
- The block drives the ALU's opcode/operand inputs, waits a fixed ALU latency, captures res, and returns it to the granted port.

Parameters:
- OP_W, 8, opcode width; equals the `AluOpBus width.
- DATA_W, 24, operand/result width; equals the `RegBus width.
- ALU_LATENCY, 1, cycles from the ALU inputs being registered to res being valid. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high (`RstEnable = 1).
- req_valid_i  in  2  bit k: port k presents an operation.
- req_ready_o  out  2  bit k: port k's operation accepted this cycle.
- req_op0_i / req_op1_i  in  OP_W  opcode, port 0 / port 1.
- req_a0_i / req_a1_i  in  DATA_W  operand 1, port 0 / port 1.
- req_b0_i / req_b1_i  in  DATA_W  operand 2, port 0 / port 1.
- resp_valid_o  out  2  bit k: result for port k available.
- resp_ready_i  in  2  bit k: port k consumes its result.
- resp_data_o  out  DATA_W  result, shared by both ports and qualified by resp_valid_o.
- aluop_o  out  OP_W  to candy_alu aluop_i.
- reg1_o  out  DATA_W  to candy_alu reg1_i.
- reg2_o  out  DATA_W  to candy_alu reg2_i.
- alu_res_i  in  DATA_W  from candy_alu res_o.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset, synchronous: state=IDLE, rr_ptr=0, cnt=0, grant=0. The following outputs are 0: req_ready_o, resp_valid_o, resp_data_o, aluop_o (`EXE_NOP = 0), reg1_o, reg2_o, busy_o.
- Reset mid-operation aborts the operation. The in-flight result is discarded and never presented.
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration (combinational):
  - If only one port is valid, grant it.
  - If both are valid, grant port rr_ptr.
  - req_ready_o[grant] is 1 in this same cycle (Mealy); the handshake completes in this cycle.
  - At the clock edge: aluop_o/reg1_o/reg2_o <= granted op/a/b; grant register <= granted port; rr_ptr <= ~granted port; cnt <= ALU_LATENCY; state -> EXEC.
  - With no valid request: stay in IDLE, req_ready_o=0.
- req_ready_o is 0 in EXEC and RESP. Requesters hold valid and payload stable until accepted.
- EXEC:
  - ALU inputs are held stable.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: resp_data_o <= alu_res_i; resp_valid_o[grant] <= 1; aluop_o/reg1_o/reg2_o <= 0; state -> RESP.
- Latency, with handshake in cycle T:
  - ALU inputs valid from T+1.
  - alu_res_i is sampled at the end of T+1+ALU_LATENCY.
  - resp_valid_o rises in cycle T+ALU_LATENCY+2.
- RESP:
  - resp_valid_o[grant] and resp_data_o are held until resp_ready_i[grant]=1.
  - At that edge: resp_valid_o <= 0; state -> IDLE.
  - The next grant can occur in the following cycle, at the earliest.
  - resp_ready_i on the non-granted bit is ignored.
- Throughput: at most one operation per ALU_LATENCY+3 cycles when responses are consumed immediately.
- resp_valid_o is at most one-hot, and is never asserted together with req_ready_o.
- The block does not interpret or modify the opcode. Result width and overflow behaviour are those of the ALU; the result is passed through unmodified.

Test Plan:
- Reset: hold rst=1 for 3 cycles with req_valid_i=2'b11 -> every output stays 0 and no request is accepted; release rst -> port 0 is granted in the first cycle.
- Single multiply, ALU_LATENCY=1, real candy_alu attached: port 0 sends `EXE_MUL, a=24'd113, b=24'd32345 at T -> req_ready_o=2'b01 at T; aluop_o=`EXE_MUL from T+1; resp_valid_o=2'b01 at T+3 with resp_data_o=24'd3654985; resp_ready_i=2'b01 -> IDLE at T+4.
- Contention: both ports valid continuously, each op an add (port 0: 1+2, port 1: 10+20), responses accepted immediately -> grants alternate 0,1,0,1; results alternate 3 and 30 on the correct resp_valid_o bit.
- Backpressure: port 1 holds resp_ready_i=0 for 5 cycles -> resp_valid_o=2'b10 and resp_data_o are stable throughout; port 0's pending request is not accepted until one cycle after port 1's response is consumed.
- Latency parameter: ALU_LATENCY=4 with a behavioural ALU model -> resp_valid_o rises exactly 6 cycles after the request handshake cycle.
- Reset mid-EXEC: assert rst for 1 cycle during EXEC -> no resp_valid_o pulse for the aborted operation; rr_ptr=0 afterwards (both ports valid -> port 0 granted).

Source files
------------

// File: rtl/candy_alu_arbiter.sv
// candy_alu_arbiter: round-robin sharing of a single candy_alu between two issue slots.
// One operation is in flight at a time; the result returns to the granted slot via valid/ready.
module candy_alu_arbiter #(
  parameter int OP_W        = 8,
  parameter int DATA_W      = 24,
  parameter int ALU_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [OP_W-1:0]   req_op0_i,
  input  logic [OP_W-1:0]   req_op1_i,
  input  logic [DATA_W-1:0] req_a0_i,
  input  logic [DATA_W-1:0] req_a1_i,
  input  logic [DATA_W-1:0] req_b0_i,
  input  logic [DATA_W-1:0] req_b1_i,
  output logic [1:0]        resp_valid_o,
  input  logic [1:0]        resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic [OP_W-1:0]   aluop_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);

  state_t     state, state_nxt;
  logic       rr_ptr;
  logic       grant;
  logic [3:0] cnt;
  logic       arb_valid;
  logic       arb_port;

  // Arbitration is gated by rst so nothing is accepted while reset is held.
  always_comb begin
    arb_valid = 1'b0;
    arb_port  = 1'b0;
    if (state == IDLE && !rst) begin
      case (req_valid_i)
        2'b01: begin arb_valid = 1'b1; arb_port = 1'b0;   end
        2'b10: begin arb_valid = 1'b1; arb_port = 1'b1;   end
        2'b11: begin arb_valid = 1'b1; arb_port = rr_ptr; end
        default: begin arb_valid = 1'b0; arb_port = 1'b0; end
      endcase
    end
  end

  assign req_ready_o = arb_valid ? (arb_port ? 2'b10 : 2'b01) : 2'b00;
  assign busy_o      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_valid) state_nxt = EXEC;
      EXEC:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (resp_ready_i[grant]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      grant        <= 1'b0;
      cnt          <= 4'd0;
      aluop_o      <= '0;
      reg1_o       <= '0;
      reg2_o       <= '0;
      resp_valid_o <= 2'b00;
      resp_data_o  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant   <= arb_port;
            rr_ptr  <= ~arb_port;
            cnt     <= LAT;
            aluop_o <= arb_port ? req_op1_i : req_op0_i;
            reg1_o  <= arb_port ? req_a1_i  : req_a0_i;
            reg2_o  <= arb_port ? req_b1_i  : req_b0_i;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_data_o  <= alu_res_i;
            resp_valid_o <= grant ? 2'b10 : 2'b01;
            aluop_o      <= '0;
            reg1_o       <= '0;
            reg2_o       <= '0;
          end
        end
        RESP: begin
          if (resp_ready_i[grant]) resp_valid_o <= 2'b00;
        end
        default: begin
          resp_valid_o <= 2'b00;
        end
      endcase
    end
  end

endmodule
